// File: rtl/tinyalu_core.sv
// TinyALU responder: accepts one op per start rising edge, returns a 16-bit result with a one-cycle done pulse.
// Optional macro TINYALU_ILLEGAL_OP_ERR_EN adds an err output and turns illegal op codes into erroring ops.
module tinyalu_core #(
    parameter int MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result,
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
    output logic        err,
`endif
    output logic        busy
);

    localparam int CW = 4;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_RST = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   counter_reg, counter_next;
    logic [15:0]     result_reg, result_next;
    logic            start_q_reg;
    logic            pending_reg;
    logic [7:0]      a_reg, b_reg;
    logic [2:0]      op_reg;
    logic            accept;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
    logic            err_reg, err_next;
`endif

    logic [8:0]      sum;
    logic [15:0]     product;
    logic [7:0]      and_bits, xor_bits;

    assign accept  = (state_reg == IDLE) && start && !start_q_reg;
    assign sum     = {1'b0, a_reg} + {1'b0, b_reg};
    assign product = {8'b0, a_reg} * {8'b0, b_reg};

    for (genvar gi = 0; gi < 8; gi++) begin : g_bitwise
        assign and_bits[gi] = a_reg[gi] & b_reg[gi];
        assign xor_bits[gi] = a_reg[gi] ^ b_reg[gi];
    end

    // Operands are latched on acceptance; the op is dispatched from those
    // registers one cycle later while the FSM is still in IDLE.
    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        result_next  = result_reg;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
        err_next     = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (pending_reg) begin
                    case (op_reg)
                        OP_ADD: begin
                            result_next = {7'b0, sum};
                            state_next  = DONE;
                        end
                        OP_AND: begin
                            result_next = {8'b0, and_bits};
                            state_next  = DONE;
                        end
                        OP_XOR: begin
                            result_next = {8'b0, xor_bits};
                            state_next  = DONE;
                        end
                        OP_MUL: begin
                            counter_next = CW'(MUL_LATENCY - 1);
                            state_next   = EXEC;
                        end
                        OP_RST: begin
                            result_next = 16'h0000;
                        end
                        OP_NOP: begin
                        end
                        default: begin
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
                            result_next = 16'h0000;
                            err_next    = 1'b1;
                            state_next  = DONE;
`endif
                        end
                    endcase
                end
            end
            EXEC: begin
                counter_next = counter_reg - CW'(1);
                if (counter_reg == CW'(1)) begin
                    result_next = product;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            result_reg  <= '0;
            start_q_reg <= 1'b0;
            pending_reg <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= '0;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
            err_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            result_reg  <= result_next;
            start_q_reg <= start;
            pending_reg <= accept;
            if (accept) begin
                a_reg  <= A;
                b_reg  <= B;
                op_reg <= op;
            end
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
            err_reg     <= err_next;
`endif
        end
    end

    assign done   = (state_reg == DONE);
    assign busy   = (state_reg == EXEC);
    assign result = result_reg;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
    assign err    = err_reg;
`endif

endmodule

// File: doc/tinyalu_core.md
Name: tinyalu_core

Overview:
- RTL responder for the TinyALU operation protocol, driven by the package tester, checked by the scoreboard and sampled by coverage.
- Accepts one operation per start rising edge and latches A, B and op.
- Single-cycle ops (add/and/xor) complete in 1 cycle; mul completes after a programmable pipeline latency.
- Returns a 16-bit result qualified by a one-cycle done pulse.

Parameters:
- MUL_LATENCY, 3, cycles from acceptance to done for mul_op; legal range 2..8.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- A  input  8  operand A, sampled at acceptance only
- B  input  8  operand B, sampled at acceptance only
- op  input  3  operation code: no_op=000, add_op=001, and_op=010, xor_op=011, mul_op=100, rst_op=111; 101/110 illegal
- start  input  1  request; a new op is accepted on a rising edge
- done  output  1  one-cycle completion strobe
- result  output  16  operation result, valid in done cycle, held until next done or clear
- busy  output  1  high while a mul is in flight

Behaviour:
- Reset (reset_n low, async): state=IDLE, done=0, result=0, busy=0, start_q=0, counter=0, operand registers=0.
- Reset mid-operation aborts the op; no done is produced after release.
- start_q is registered every cycle in all states.
- Acceptance condition: state==IDLE && start==1 && start_q==0, sampled at posedge k. A, B and op are latched at posedge k; later changes on A/B/op are ignored.
- A rising edge of start seen outside IDLE is discarded. The tester must drop start and raise it again.
- FSM states:
  - IDLE: on acceptance, add/and/xor -> DONE; mul -> EXEC with counter=MUL_LATENCY-1; no_op/rst_op/illegal -> stay IDLE.
  - EXEC: counter decrements each cycle; when counter==1, next state=DONE and result<=product.
  - DONE: done=1 for exactly this cycle; next state always IDLE.
- Outputs are decoded from state: done=(state==DONE), busy=(state==EXEC).
- Latency: add/and/xor give done high in the cycle after posedge k+1. mul gives done high in the cycle after posedge k+MUL_LATENCY.
- Arithmetic:
  - add: result={7'b0, A+B}; 9-bit sum, carry in bit 8.
  - and: {8'b0, A&B}.
  - xor: {8'b0, A^B}.
  - mul: A*B, full 16-bit unsigned product.
- no_op: accepted, no state change, result unchanged, no done.
- rst_op: accepted in IDLE, result<=0 at posedge k+1, no done, stays IDLE.
- If start drops during EXEC, the op still completes and done still pulses.
- Back-to-back ops: the earliest next acceptance is the first IDLE cycle with a fresh start rising edge, i.e. two cycles after the previous done at minimum.
- Operands 8'hFF/8'hFF: add gives 16'h01FE; mul gives 16'hFE01. No overflow or wrap in 16 bits.

Optional Feature:
- Macro TINYALU_ILLEGAL_OP_ERR_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - An accepted illegal op (101/110) goes IDLE->DONE with result<=0 and err=1 during the done cycle only.
  - err is 0 with every legal done.
- Not defined:
  - No err port.
  - Illegal op codes behave exactly as no_op: no done, result unchanged.

Test Plan:
- Async reset asserted between clock edges during an EXEC mul -> done, busy and result drop to 0 immediately; no done after reset release.
- add_op A=8'hFF B=8'h01, start rise at posedge k -> done=1 in the cycle after posedge k+1 with result=16'h0100; done low the next cycle.
- mul_op A=8'hFF B=8'hFF, MUL_LATENCY=3, A/B changed to 8'h00 after acceptance -> busy high for 2 cycles, done after posedge k+3, result=16'hFE01.
- xor_op A=8'hAA B=8'h0F with start held high through done and for 3 further cycles -> exactly one done (result=16'h00A5); no second op until start toggles low then high.
- Sequence add (result 16'h0010), then rst_op, then no_op -> rst_op yields result=16'h0000 with no done; no_op gives no done and result stays 16'h0000.
- Illegal op 3'b101 -> with TINYALU_ILLEGAL_OP_ERR_EN: done=1, err=1, result=0 for one cycle; without the macro: no done and result unchanged.
